uart_rx_queue: RTL and testbench
================================

UART_RX_QUEUE -- requirements
Module: uart_rx_queue

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (legal range >= 4).
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, log2 of the FIFO depth (2^3 = 8 bytes).
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_X  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port RXD  input  1  asynchronous serial line from the processor's txd; idle high.
REQ-006 SHALL have port VALID  output  1  FIFO head byte available.
REQ-007 SHALL have port READY  input  1  consumer accepts the head byte when VALID&READY.
REQ-008 SHALL have port DATA  output  8  FIFO head byte; value is don't-care when VALID=0.
REQ-009 SHALL have port COUNT  output  DEPTH_LOG2+1  number of bytes held.
REQ-010 SHALL have port FERR  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port OVF  output  1  one-cycle pulse: received byte dropped because the FIFO was full.

Function
REQ-012 SHALL pass RXD through a 2-flop synchronizer (flops reset to 1); all logic uses the synchronized value rxs.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP with one bit-timer counter and a 3-bit bit index.
REQ-014 IDLE: on a rxs falling edge (previous 1, current 0), SHALL go to START and load the timer with CLKS_PER_BIT/2 - 1.
REQ-015 START: at timer==0, SHALL sample rxs; 0 -> DATA with timer=CLKS_PER_BIT-1 and index=0; 1 -> IDLE (glitch, nothing reported).
REQ-016 DATA: at each timer==0, SHALL shift rxs into the shift register LSB-first and reload the timer; after index 7, go to STOP.
REQ-017 STOP: at timer==0, SHALL sample rxs; 1 -> push the byte; 0 -> discard the byte and pulse FERR; go to IDLE in both cases.
REQ-018 After FERR, SHALL detect a new start only after rxs has been seen high, via the falling-edge rule in REQ-014.
REQ-019 FIFO SHALL be a circular buffer of 2^DEPTH_LOG2 entries with wrap-around read/write pointers.
REQ-020 DATA SHALL always reflect the entry at the read pointer.
REQ-021 Push SHALL occur on the STOP-sample edge; VALID rises in the following cycle, with no same-cycle bypass.
REQ-022 Pop SHALL occur on each edge with VALID&READY; READY while VALID=0 has no effect.
REQ-023 Push while full and no pop in the same cycle: SHALL drop the byte, pulse OVF, and leave the FIFO contents unchanged.
REQ-024 Push while full with a pop in the same cycle: SHALL accept both; COUNT is unchanged and there is no OVF.
REQ-025 Simultaneous push and pop at any fill level SHALL keep COUNT constant.
REQ-026 COUNT SHALL saturate exactly at 2^DEPTH_LOG2 and never wrap.
REQ-027 VALID SHALL equal (COUNT != 0).
REQ-028 FERR and OVF SHALL be registered outputs, high for exactly one cycle per event.
REQ-029 The receiver SHALL NOT stall on FIFO state: reception continues while full.

Reset
REQ-030 While RST_X=0, SHALL set: FSM=IDLE, synchronizer flops=1, pointers=0, COUNT=0, VALID=0, DATA=8'h00, FERR=0, OVF=0, shift register=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame, with no partial byte pushed.
REQ-032 After RST_X deasserts, the first frame SHALL be recognised only from a falling edge, so a line held low through reset is not taken as a start.

Verification (CLKS_PER_BIT=4, DEPTH_LOG2=3)
REQ-033 Send frame 0x41 with READY=0 -> after the stop sample, VALID=1, DATA=8'h41, COUNT=1; FERR=0, OVF=0.
REQ-034 Low pulse of 1 cycle on idle RXD -> FSM returns to IDLE, COUNT stays 0, no FERR.
REQ-035 Frame 0x55 with stop bit held low -> one FERR pulse, COUNT=0; next good frame 0x0A -> DATA=8'h0A.
REQ-036 Nine back-to-back frames 0x01..0x09 with READY=0 -> COUNT=8, one OVF pulse on the ninth; pop all -> sequence 0x01..0x08.
REQ-037 FIFO full with READY=1 asserted in the same cycle as the 9th push -> no OVF, COUNT=8, popped byte=0x01, tail=0x09.
REQ-038 RST_X pulsed low during data bit 4 of a frame, with RXD held low across reset -> COUNT=0, no byte pushed; the next complete frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_queue
// Brief    : 8N1 UART receiver feeding a circular byte FIFO with a valid/ready head.
// Revision : 1.0
// ============================================================================
module uart_rx_queue #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic                  CLK,
    input  logic                  RST_X,
    input  logic                  RXD,
    output logic                  VALID,
    input  logic                  READY,
    output logic [7:0]            DATA,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  FERR,
    output logic                  OVF
);

    localparam int                c_DEPTH    = 1 << DEPTH_LOG2;
    localparam int                c_TW       = $clog2(CLKS_PER_BIT);
    localparam int                c_CW       = DEPTH_LOG2 + 1;
    localparam logic [c_TW-1:0]   c_T_HALF   = c_TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TW-1:0]   c_T_FULL   = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0]   c_T_ONE    = c_TW'(1);
    localparam logic [c_CW-1:0]   c_CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic                   sync1_q;
    logic                   rxs_q;
    logic [1:0]             warm_q;
    logic                   rxs_prev_q;
    state_t                 state_q, state_d;
    logic [c_TW-1:0]        timer_q, timer_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             mem_q [c_DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [c_CW-1:0]        count_q, count_d;
    logic                   ferr_q, ovf_q;

    logic                   w_fall;
    logic                   w_stop_ok;
    logic                   w_stop_bad;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_ovf;

    // rxs_prev only tracks the line once the synchronizer holds real samples,
    // so a line held low through reset never looks like a falling edge.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            warm_q     <= 2'b00;
            rxs_prev_q <= 1'b0;
        end else begin
            sync1_q    <= RXD;
            rxs_q      <= sync1_q;
            warm_q     <= {warm_q[0], 1'b1};
            rxs_prev_q <= warm_q[1] & rxs_q;
        end
    end

    assign w_fall = rxs_prev_q & ~rxs_q;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        w_stop_ok  = 1'b0;
        w_stop_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_fall) begin
                    state_d = ST_START;
                    timer_d = c_T_HALF;
                end
            end
            ST_START: begin
                if (timer_q == '0) begin
                    if (!rxs_q) begin
                        state_d = ST_DATA;
                        timer_d = c_T_FULL;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - c_T_ONE;
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    timer_d = c_T_FULL;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - c_T_ONE;
                end
            end
            ST_STOP: begin
                if (timer_q == '0) begin
                    w_stop_ok  = rxs_q;
                    w_stop_bad = ~rxs_q;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q - c_T_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign w_full = (count_q == c_CNT_FULL);
    assign w_pop  = (count_q != '0) & READY;
    assign w_push = w_stop_ok & (~w_full | w_pop);
    assign w_ovf  = w_stop_ok & w_full & ~w_pop;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            count_q <= count_d;
            ferr_q  <= w_stop_bad;
            ovf_q   <= w_ovf;
        end
    end

    assign VALID = (count_q != '0);
    assign DATA  = mem_q[rd_ptr_q];
    assign COUNT = count_q;
    assign FERR  = ferr_q;
    assign OVF   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_queue
// Brief    : Self-checking bench for uart_rx_queue; bytes queued on send, compared on pop.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_queue;

    localparam int CLKS_PER_BIT = 4;
    localparam int DEPTH_LOG2   = 3;

    logic                  CLK   = 1'b0;
    logic                  RST_X = 1'b0;
    logic                  RXD   = 1'b1;
    logic                  READY = 1'b0;
    logic                  VALID;
    logic [7:0]            DATA;
    logic [DEPTH_LOG2:0]   COUNT;
    logic                  FERR;
    logic                  OVF;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ferr_cnt = 0;
    int         ovf_cnt  = 0;
    int         f0;
    int         o0;
    logic [7:0] sb_q [$];

    always #5 CLK = ~CLK;

    uart_rx_queue #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DEPTH_LOG2   (DEPTH_LOG2)
    ) u_dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .RXD   (RXD),
        .VALID (VALID),
        .READY (READY),
        .DATA  (DATA),
        .COUNT (COUNT),
        .FERR  (FERR),
        .OVF   (OVF)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse counters and handshake scoreboard, sampled mid-cycle.
    always begin
        @(negedge CLK);
        #1;
        if (FERR === 1'b1) ferr_cnt++;
        if (OVF === 1'b1)  ovf_cnt++;
        if (VALID === 1'b1 && READY === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("pop_with_empty_scoreboard", 32'(sb_q.size()), 32'd1);
            end else begin
                check_eq("pop_data", {24'b0, DATA}, {24'b0, sb_q.pop_front()});
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
        RXD = 1'b0;
        wait_cycles(CLKS_PER_BIT);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            wait_cycles(CLKS_PER_BIT);
        end
        RXD = stop_bit;
        wait_cycles(CLKS_PER_BIT);
        RXD = 1'b1;
        if (pop_at_stop) begin
            READY = 1'b1;
            wait_cycles(1);
            READY = 1'b0;
            wait_cycles(5);
        end else begin
            wait_cycles(6);
        end
    endtask

    task automatic drain(input string tag);
        READY = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            wait_cycles(1);
        end
        wait_cycles(1);
        READY = 1'b0;
        check_eq(tag, 32'(sb_q.size()), 32'd0);
        check_eq({tag, "_count"}, 32'(COUNT), 32'd0);
    endtask

    initial begin
        wait_cycles(3);
        check_eq("rst_valid", 32'(VALID), 32'd0);
        check_eq("rst_count", 32'(COUNT), 32'd0);
        check_eq("rst_data",  32'(DATA),  32'd0);
        check_eq("rst_ferr",  32'(FERR),  32'd0);
        check_eq("rst_ovf",   32'(OVF),   32'd0);
        RST_X = 1'b1;
        wait_cycles(4);

        // Single good frame, consumer stalled
        f0 = ferr_cnt;
        o0 = ovf_cnt;
        sb_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 1'b0);
        check_eq("f41_valid", 32'(VALID), 32'd1);
        check_eq("f41_data",  32'(DATA),  32'h41);
        check_eq("f41_count", 32'(COUNT), 32'd1);
        check_eq("f41_ferr",  32'(ferr_cnt - f0), 32'd0);
        check_eq("f41_ovf",   32'(ovf_cnt - o0),  32'd0);
        drain("drain_41");

        // One-cycle glitch on idle line
        f0 = ferr_cnt;
        RXD = 1'b0;
        wait_cycles(1);
        RXD = 1'b1;
        wait_cycles(12);
        check_eq("glitch_count", 32'(COUNT), 32'd0);
        check_eq("glitch_valid", 32'(VALID), 32'd0);
        check_eq("glitch_ferr",  32'(ferr_cnt - f0), 32'd0);

        // Framing error then recovery
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        check_eq("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
        check_eq("ferr_count", 32'(COUNT), 32'd0);
        sb_q.push_back(8'h0A);
        send_frame(8'h0A, 1'b1, 1'b0);
        check_eq("after_ferr_data",  32'(DATA),  32'h0A);
        check_eq("after_ferr_count", 32'(COUNT), 32'd1);
        drain("drain_0a");

        // Overflow: ninth byte dropped
        o0 = ovf_cnt;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) sb_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
        end
        check_eq("ovf_count", 32'(COUNT), 32'd8);
        check_eq("ovf_pulse", 32'(ovf_cnt - o0), 32'd1);
        check_eq("ovf_head",  32'(DATA), 32'h01);
        drain("drain_ovf");

        // Full FIFO with pop on the same edge as the ninth push
        for (int i = 1; i <= 8; i++) begin
            sb_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
        end
        check_eq("full_count", 32'(COUNT), 32'd8);
        o0 = ovf_cnt;
        sb_q.push_back(8'h09);
        send_frame(8'h09, 1'b1, 1'b1);
        check_eq("pushpop_count", 32'(COUNT), 32'd8);
        check_eq("pushpop_ovf",   32'(ovf_cnt - o0), 32'd0);
        check_eq("pushpop_head",  32'(DATA), 32'h02);
        drain("drain_pushpop");

        // Reset during data bit 4 with line held low across reset
        f0 = ferr_cnt;
        RXD = 1'b0;
        wait_cycles(CLKS_PER_BIT);
        for (int i = 0; i < 4; i++) begin
            RXD = 1'b1;
            wait_cycles(CLKS_PER_BIT);
        end
        RXD = 1'b1;
        wait_cycles(2);
        RXD = 1'b0;
        wait_cycles(1);
        RST_X = 1'b0;
        wait_cycles(1);
        check_eq("midrst_count", 32'(COUNT), 32'd0);
        check_eq("midrst_valid", 32'(VALID), 32'd0);
        RST_X = 1'b1;
        wait_cycles(12);
        check_eq("lowline_count", 32'(COUNT), 32'd0);
        check_eq("lowline_valid", 32'(VALID), 32'd0);
        check_eq("lowline_ferr",  32'(ferr_cnt - f0), 32'd0);
        RXD = 1'b1;
        wait_cycles(8);
        sb_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0);
        check_eq("c3_data",  32'(DATA),  32'hC3);
        check_eq("c3_count", 32'(COUNT), 32'd1);
        check_eq("c3_ferr",  32'(ferr_cnt - f0), 32'd0);
        drain("drain_c3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
